// File: rtl/huff_pkg.sv
// huff_pkg: shared state encoding, table-id and sample types for the Huffman big_values sequencer.
package huff_pkg;
   typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EMIT_Y, S_ZERO_X, S_ZERO_Y, S_DONE} state_t;
   localparam int MAX_SAMPLES = 576;
   localparam int SAMPLE_W = 16;
   typedef logic [4:0] tbl_t;
   typedef logic signed [SAMPLE_W-1:0] sample_t;
   localparam tbl_t TBL_ZERO = 5'd0;
endpackage

// File: rtl/huff_region_select.sv
// huff_region_select: maps a sample index to the Huffman table id of its region.
// An inverted region2 boundary simply leaves region 1 empty.
module huff_region_select
   import huff_pkg::*;
#(
   parameter int ADDR_W = 10
) (
   input  logic [ADDR_W-1:0] i_idx,
   input  logic [ADDR_W-1:0] i_r1_start,
   input  logic [ADDR_W-1:0] i_r2_start,
   input  tbl_t              i_sel0,
   input  tbl_t              i_sel1,
   input  tbl_t              i_sel2,
   output tbl_t              o_sel
);
   assign o_sel = (i_idx < i_r1_start) ? i_sel0 : (i_idx < i_r2_start) ? i_sel1 : i_sel2;
endmodule

// File: rtl/huff_region_sched.sv
// huff_region_sched: sequences big_values Huffman decoding, one bit per cycle, into the sample buffer.
// Optional macro HUFF_BITBUDGET_EN adds a consumed-bit counter that aborts the granule on budget overrun.
module huff_region_sched
   import huff_pkg::*;
#(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 10,
   parameter int BUDGET_W = 12
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic [8:0]               big_values,
   input  logic [ADDR_W-1:0]        region1_start,
   input  logic [ADDR_W-1:0]        region2_start,
   input  logic [4:0]               table_sel0,
   input  logic [4:0]               table_sel1,
   input  logic [4:0]               table_sel2,
   input  logic [BUDGET_W-1:0]      bit_budget,
   input  logic                     axiiv,
   input  logic                     axiid,
   output logic                     axiir,
   output logic [4:0]               dec_sel,
   output logic                     dec_axiiv,
   output logic                     dec_axiid,
   input  logic                     dec_axiov,
   input  logic signed [DATA_W-1:0] dec_x,
   input  logic signed [DATA_W-1:0] dec_y,
   output logic                     wr_en,
   output logic [ADDR_W-1:0]        wr_addr,
   output logic signed [DATA_W-1:0] wr_data,
   output logic                     busy,
   output logic                     done,
   output logic                     err
);
   localparam logic [8:0] MAX_PAIRS = 9'(MAX_SAMPLES / 2);
   state_t r_state, w_next;
   logic [ADDR_W-1:0] r_idx, r_r1, r_r2;
   tbl_t r_s0, r_s1, r_s2, w_sel_cur, w_sel_nxt, w_sel_st;
   logic [8:0] r_bv, r_pair;
   logic signed [DATA_W-1:0] r_y;
   logic r_err, w_dec, w_ydone, w_last, w_over, w_fault, w_start;

   huff_region_select #(.ADDR_W(ADDR_W)) u_sel_cur (.i_idx(r_idx), .i_r1_start(r_r1), .i_r2_start(r_r2),
      .i_sel0(r_s0), .i_sel1(r_s1), .i_sel2(r_s2), .o_sel(w_sel_cur));
   huff_region_select #(.ADDR_W(ADDR_W)) u_sel_nxt (.i_idx(r_idx + ADDR_W'(2)), .i_r1_start(r_r1), .i_r2_start(r_r2),
      .i_sel0(r_s0), .i_sel1(r_s1), .i_sel2(r_s2), .o_sel(w_sel_nxt));
   huff_region_select #(.ADDR_W(ADDR_W)) u_sel_st (.i_idx('0), .i_r1_start(region1_start), .i_r2_start(region2_start),
      .i_sel0(table_sel0), .i_sel1(table_sel1), .i_sel2(table_sel2), .o_sel(w_sel_st));

   assign w_dec   = r_state == S_DECODE;
   assign w_ydone = r_state == S_EMIT_Y || r_state == S_ZERO_Y;
   assign w_last  = r_pair + 9'd1 == r_bv;
   assign w_start = r_state == S_IDLE && start;
   // overrun means a bit is offered after the budget is already spent
   assign w_fault = w_dec && axiiv && !dec_axiov && w_over;

`ifdef HUFF_BITBUDGET_EN
   logic [BUDGET_W-1:0] r_bits, r_budget;
   assign w_over = r_bits == r_budget;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_bits   <= '0;
         r_budget <= '0;
      end else if (w_start) begin
         r_bits   <= '0;
         r_budget <= bit_budget;
      end else if (axiir) r_bits <= r_bits + BUDGET_W'(1);
   end
`else
   logic w_unused_budget;
   assign w_unused_budget = ^bit_budget;
   assign w_over = 1'b0;
`endif

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (start) w_next = (big_values == 9'd0) ? S_DONE : (w_sel_st == TBL_ZERO) ? S_ZERO_X : S_DECODE;
         S_DECODE: w_next = dec_axiov ? S_EMIT_Y : w_fault ? S_DONE : S_DECODE;
         S_EMIT_Y, S_ZERO_Y: w_next = w_last ? S_DONE : (w_sel_nxt == TBL_ZERO) ? S_ZERO_X : S_DECODE;
         S_ZERO_X: w_next = S_ZERO_Y;
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_idx   <= '0;
         r_r1    <= '0;
         r_r2    <= '0;
         r_s0    <= '0;
         r_s1    <= '0;
         r_s2    <= '0;
         r_bv    <= '0;
         r_pair  <= '0;
         r_y     <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_start) begin
            r_idx  <= '0;
            r_pair <= '0;
            r_err  <= 1'b0;
            r_r1   <= region1_start;
            r_r2   <= region2_start;
            r_s0   <= table_sel0;
            r_s1   <= table_sel1;
            r_s2   <= table_sel2;
            r_bv   <= (big_values > MAX_PAIRS) ? MAX_PAIRS : big_values;
         end
         if (w_dec && dec_axiov) r_y <= dec_y;
         if (w_ydone) begin
            r_idx  <= r_idx + ADDR_W'(2);
            r_pair <= r_pair + 9'd1;
         end
         if (w_fault) r_err <= 1'b1;
      end
   end

   // strobes are gated by rst_n so an aborting reset suppresses the write in flight
   assign dec_axiiv = rst_n && w_dec && axiiv && !dec_axiov && !w_over;
   assign axiir     = dec_axiiv;
   assign dec_axiid = w_dec && axiid;
   assign dec_sel   = w_sel_cur;
   assign wr_en     = rst_n && ((w_dec && dec_axiov) || w_ydone || r_state == S_ZERO_X);
   assign wr_addr   = w_ydone ? r_idx + ADDR_W'(1) : r_idx;
   assign wr_data   = (w_dec && dec_axiov) ? dec_x : (r_state == S_EMIT_Y) ? r_y : '0;
   assign busy      = r_state != S_IDLE;
   assign done      = r_state == S_DONE;
   assign err       = r_err;
endmodule
